// File: rtl/ifetch_port_pkg.sv
// ifetch_port_pkg: shared busio types and constants for the instruction fetch port
package ifetch_port_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  // addi x0,x0,0; also used by decode as its bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int WORD_AW = 30;
endpackage

// File: rtl/ifetch_port.sv
// ifetch_port: one-entry instruction buffer with a valid/ready read port to instruction memory
//   clk, reset (async, active-high)
//   fetch_address -> fetch_data / fetch_busy / fetch_error (combinational from the buffer)
//   flush         : invalidate buffer; a pending read is consumed but not written
//   mem_req_*     : read request (valid/ready), word-aligned address held until accepted
//   mem_resp_*    : read response pulse with data and error
module ifetch_port
  import ifetch_port_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = ifetch_port_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_busy,
  output logic        fetch_error,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_error
);
  state_t             state_q, state_d;
  logic               buf_valid_q, buf_valid_d;
  logic [WORD_AW-1:0] buf_addr_q, buf_addr_d;
  logic [31:0]        buf_data_q, buf_data_d;
  logic               buf_err_q, buf_err_d;
  logic               discard_q, discard_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic               hit;
  logic               unused_bits;
  assign unused_bits   = ^fetch_address[1:0];
  assign hit           = buf_valid_q && buf_addr_q == fetch_address[31:2];
  assign fetch_data    = hit ? buf_data_q : NOP_INSTR;
  assign fetch_busy    = !hit;
  assign fetch_error   = hit && buf_err_q;
  assign mem_req_valid = state_q == REQ;
  assign mem_req_addr  = req_addr_q;
  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_err_d   = buf_err_q;
    discard_d   = discard_q;
    req_addr_d  = req_addr_q;
    case (state_q)
      IDLE: if (!hit) begin
        req_addr_d = {fetch_address[31:2], 2'b00};
        discard_d  = 1'b0;
        state_d    = REQ;
      end
      REQ: begin
        discard_d = discard_q || flush;
        state_d   = mem_req_ready ? WAIT : REQ;
      end
      WAIT: begin
        discard_d = discard_q || flush;
        if (mem_resp_valid) begin
          // a flush in the response cycle also drops the word
          if (!discard_q && !flush) begin
            buf_addr_d  = req_addr_q[31:2];
            buf_data_d  = mem_resp_data;
            buf_err_d   = mem_resp_error;
            buf_valid_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) buf_valid_d = 1'b0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_err_q   <= 1'b0;
      discard_q   <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_err_q   <= buf_err_d;
      discard_q   <= discard_d;
      req_addr_q  <= req_addr_d;
    end
  end
endmodule

// File: tb/tb_ifetch_port.sv
// tb_ifetch_port: directed cycle-by-cycle checks of the instruction fetch port
module tb_ifetch_port;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_address;
  logic [31:0] fetch_data;
  logic        fetch_busy;
  logic        fetch_error;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_error;
  int          errors = 0;
  int          checks = 0;
  ifetch_port dut (
    .clk(clk), .reset(reset), .fetch_address(fetch_address), .fetch_data(fetch_data),
    .fetch_busy(fetch_busy), .fetch_error(fetch_error), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_error(mem_resp_error)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle_out(input string tag, input logic [31:0] data, input logic busy, input logic err);
    chk({tag, "_data"}, fetch_data, data);
    chk({tag, "_busy"}, {31'b0, fetch_busy}, {31'b0, busy});
    chk({tag, "_err"}, {31'b0, fetch_error}, {31'b0, err});
  endtask
  task automatic req_out(input string tag, input logic v, input logic [31:0] a);
    chk({tag, "_rv"}, {31'b0, mem_req_valid}, {31'b0, v});
    if (v) chk({tag, "_ra"}, mem_req_addr, a);
  endtask
  initial begin
    reset = 1'b1; fetch_address = 32'h8000_0000; flush = 1'b0; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_error = 1'b0;
    #2;
    idle_out("rst", 32'h13, 1'b1, 1'b0);
    chk("rst_rv", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_ra", mem_req_addr, 32'd0);
    // zero-wait fill: miss cycle 0, REQ 1, response 2, hit 3
    tick; reset = 1'b0;
    idle_out("c0", 32'h13, 1'b1, 1'b0);
    req_out("c0", 1'b0, 0);
    tick;
    req_out("c1", 1'b1, 32'h8000_0000);
    tick;
    req_out("c2", 1'b0, 0);
    idle_out("c2", 32'h13, 1'b1, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0297;
    tick; mem_resp_valid = 1'b0;
    idle_out("c3", 32'h0000_0297, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      req_out("hold", 1'b0, 0);
    end
    // back-pressure with branch during REQ
    flush = 1'b1; mem_req_ready = 1'b0;
    tick; flush = 1'b0;
    idle_out("fl_miss", 32'h13, 1'b1, 1'b0);
    tick;
    fetch_address = 32'h8000_0100;
    for (int i = 0; i < 4; i++) begin
      req_out("bp", 1'b1, 32'h8000_0000);
      tick;
    end
    mem_req_ready = 1'b1;
    req_out("bp_hs", 1'b1, 32'h8000_0000);
    tick;
    req_out("bp_wait", 1'b0, 0);
    idle_out("bp_wait", 32'h13, 1'b1, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_0000;
    tick; mem_resp_valid = 1'b0;
    idle_out("new_miss", 32'h13, 1'b1, 1'b0);
    fetch_address = 32'h8000_0000; #1;
    idle_out("old_fill", 32'h1111_0000, 1'b0, 1'b0);
    fetch_address = 32'h8000_0100; #1;
    tick;
    req_out("req2", 1'b1, 32'h8000_0100);
    tick;
    idle_out("w2a", 32'h13, 1'b1, 1'b0);
    tick;
    idle_out("w2b", 32'h13, 1'b1, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h2222_0100;
    tick; mem_resp_valid = 1'b0;
    idle_out("fill2", 32'h2222_0100, 1'b0, 1'b0);
    // flush during WAIT discards the response
    flush = 1'b1;
    tick; flush = 1'b0;
    tick;
    req_out("fr", 1'b1, 32'h8000_0100);
    tick;
    flush = 1'b1;
    tick; flush = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
    tick; mem_resp_valid = 1'b0;
    idle_out("disc", 32'h13, 1'b1, 1'b0);
    req_out("disc", 1'b0, 0);
    tick;
    req_out("reissue", 1'b1, 32'h8000_0100);
    tick;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h3333_0100;
    tick; mem_resp_valid = 1'b0;
    idle_out("fill3", 32'h3333_0100, 1'b0, 1'b0);
    // cached bus error
    fetch_address = 32'h8000_0010;
    tick;
    req_out("er", 1'b1, 32'h8000_0010);
    tick;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0; mem_resp_error = 1'b1;
    tick; mem_resp_valid = 1'b0; mem_resp_error = 1'b0;
    idle_out("err", 32'h0, 1'b0, 1'b1);
    tick;
    idle_out("err_hold", 32'h0, 1'b0, 1'b1);
    fetch_address = 32'h8000_0014; #1;
    idle_out("err_move", 32'h13, 1'b1, 1'b0);
    tick;
    req_out("er14", 1'b1, 32'h8000_0014);
    tick;
    // async reset in WAIT
    #2 reset = 1'b1;
    #1;
    req_out("areset", 1'b0, 0);
    idle_out("areset", 32'h13, 1'b1, 1'b0);
    fetch_address = 32'h8000_0010; #1;
    idle_out("areset_buf", 32'h13, 1'b1, 1'b0);
    tick; reset = 1'b0; fetch_address = 32'h8000_0014;
    req_out("rs_idle", 1'b0, 0);
    tick;
    req_out("rs_req", 1'b1, 32'h8000_0014);
    tick;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h4444_0014;
    tick; mem_resp_valid = 1'b0;
    idle_out("rs_fill", 32'h4444_0014, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
